// File: rtl/bnn_pkg.sv
// Shared types and sizing helpers for the BNN front-end and classifier wrappers.
package bnn_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DEF_FEAT_CNT  = 12;
    localparam int DEF_FEAT_BITS = 4;
    localparam int DEF_CLASS_CNT = 6;

    localparam int PRED_W = $clog2(DEF_CLASS_CNT);
    localparam int IDX_W  = $clog2(DEF_FEAT_CNT);

    // Rolled classifier needs one cycle per hidden neuron, one per class, plus pipeline fill.
    function automatic int default_settle(input int hidden_cnt, input int class_cnt);
        return hidden_cnt + class_cnt + 2;
    endfunction

endpackage

// File: rtl/bnn_feat_loader.sv
// Packs feature beats into a frame, restarts the classifier and captures its prediction.
// Latency: result valid SETTLE_CYCLES+1 cycles after the final beat is accepted.
// Backpressure: in_ready only in LOAD; result held on out_valid until out_ready.
module bnn_feat_loader
    import bnn_pkg::*;
#(
    parameter int FEAT_CNT      = DEF_FEAT_CNT,
    parameter int FEAT_BITS     = DEF_FEAT_BITS,
    parameter int CLASS_CNT     = DEF_CLASS_CNT,
    parameter int SETTLE_CYCLES = 48
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [FEAT_BITS-1:0]           in_feat,
    input  logic                           in_last,
    output logic [FEAT_CNT*FEAT_BITS-1:0]  features,
    output logic                           clf_rst,
    input  logic [$clog2(CLASS_CNT)-1:0]   pred_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(CLASS_CNT)-1:0]   out_pred,
    output logic                           frame_err
);

    localparam int IDX_BITS = $clog2(FEAT_CNT);
    localparam int CNT_BITS = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FEAT_CNT - 1);
    localparam logic [CNT_BITS-1:0] CNT_DONE = CNT_BITS'(SETTLE_CYCLES);

    state_t                state;
    state_t                state_nxt;
    logic [IDX_BITS-1:0]   idx;
    logic [CNT_BITS-1:0]   cnt;
    logic                  beat_acc;
    logic                  beat_end;
    logic                  beat_good;
    logic                  settle_done;

    assign beat_acc    = in_valid && in_ready;
    assign beat_end    = in_last && (idx == LAST_IDX);
    // in_last must coincide exactly with the final slot; anything else is a framing error.
    assign beat_good   = (in_last == (idx == LAST_IDX));
    // The counter starts at 0 on the first HOLD edge, so the classifier has had
    // SETTLE_CYCLES run cycles when it reaches SETTLE_CYCLES.
    assign settle_done = (cnt == CNT_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (beat_acc && beat_end) state_nxt = HOLD;
            HOLD:    if (settle_done)          state_nxt = OUT;
            OUT:     if (out_ready)            state_nxt = LOAD;
            default:                           state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD);
        clf_rst  = (state == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            cnt       <= '0;
            features  <= '0;
            out_valid <= 1'b0;
            out_pred  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                LOAD: begin
                    cnt <= '0;
                    if (beat_acc) begin
                        if (beat_good) begin
                            features[int'(idx)*FEAT_BITS +: FEAT_BITS] <= in_feat;
                            idx <= beat_end ? '0 : idx + IDX_BITS'(1);
                        end else begin
                            frame_err <= 1'b1;
                            idx       <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (settle_done) begin
                        out_pred  <= pred_in;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_BITS'(1);
                    end
                end
                OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_feat_loader.sv
// Directed and table-driven checks of the feature loader against hand-computed frames.
`timescale 1ns/1ps
module tb_bnn_feat_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_feat;
    logic        in_last;
    logic [47:0] features;
    logic        clf_rst;
    logic [2:0]  pred_in;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_pred;
    logic        frame_err;

    logic [2:0]  pred_drv;
    logic [2:0]  model_pred;
    bit          use_model;

    int passes = 0;
    int total  = 0;

    typedef struct {
        logic [47:0] feats;
        int          nbeats;
        bit          last_flag;
        logic [2:0]  pred;
        bit          exp_err;
        logic [47:0] exp_feat;
    } vec_t;

    vec_t vecs[6];
    logic [2:0] exp_q[$];

    bnn_feat_loader #(
        .FEAT_CNT(12), .FEAT_BITS(4), .CLASS_CNT(6), .SETTLE_CYCLES(48)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat), .in_last(in_last),
        .features(features), .clf_rst(clf_rst), .pred_in(pred_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_pred(out_pred),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Stand-in classifier: nibble sum modulo class count.
    function automatic logic [2:0] pred_of(input logic [47:0] f);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 12; i++) s = s + 8'(f[i*4 +: 4]);
        return 3'(s % 8'd6);
    endfunction

    always_comb model_pred = pred_of(features);
    assign pred_in = use_model ? model_pred : pred_drv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_beat(input logic [3:0] f, input bit l, output bit ok);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_feat  = f;
        in_last  = l;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        ok = in_ready;
        if (ok) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] fr, input int nbeats, input bit last_flag);
        bit ok;
        int acc;
        acc = 0;
        for (int k = 0; k < nbeats; k++) begin
            send_beat(fr[k*4 +: 4], (k == nbeats - 1) ? last_flag : 1'b0, ok);
            if (ok) acc++;
        end
        check("beats accepted", 64'(acc), 64'(nbeats));
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int hits;
        pred_drv  = v.pred;
        out_ready = 1'b1;
        send_frame(v.feats, v.nbeats, v.last_flag);
        if (v.exp_err) begin
            check("frame_err pulse", 64'(frame_err), 64'd1);
            @(posedge clk); #1;
            check("frame_err one cycle", 64'(frame_err), 64'd0);
            check("clf_rst after err", 64'(clf_rst), 64'd1);
            check("in_ready after err", 64'(in_ready), 64'd1);
            check("features after err", 64'(features), 64'(v.exp_feat));
            hits = 0;
            repeat (60) begin
                @(posedge clk); #1;
                if (out_valid || !clf_rst) hits++;
            end
            check("no hold after err", 64'(hits), 64'd0);
        end else begin
            check("clf_rst low after last", 64'(clf_rst), 64'd0);
            check("features packed", 64'(features), 64'(v.exp_feat));
            wait_result(n);
            check("result latency", 64'(n), 64'd49);
            check("out_pred", 64'(out_pred), 64'(v.pred));
            @(posedge clk); #1;
            check("out_valid after hs", 64'(out_valid), 64'd0);
            check("in_ready after hs", 64'(in_ready), 64'd1);
            check("clf_rst after hs", 64'(clf_rst), 64'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int hits;
        rst = 1'b1; in_valid = 1'b0; in_feat = '0; in_last = 1'b0;
        out_ready = 1'b0; pred_drv = '0; use_model = 1'b0;

        vecs[0] = '{48'hCBA987654321, 12, 1'b1, 3'd3, 1'b0, 48'hCBA987654321};
        vecs[1] = '{48'h0000000EDCBA,  5, 1'b1, 3'd0, 1'b1, 48'hCBA98765DCBA};
        vecs[2] = '{48'hFFFFFFFFFFFF, 12, 1'b1, 3'd5, 1'b0, 48'hFFFFFFFFFFFF};
        vecs[3] = '{48'h111111111111, 12, 1'b0, 3'd0, 1'b1, 48'hF11111111111};
        vecs[4] = '{48'h0123456789AB, 12, 1'b1, 3'd1, 1'b0, 48'h0123456789AB};
        vecs[5] = '{48'h5A5A5A5A5A5A, 12, 1'b1, 3'd4, 1'b0, 48'h5A5A5A5A5A5A};

        #3;
        check("reset features", 64'(features), 64'd0);
        check("reset clf_rst", 64'(clf_rst), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_pred", 64'(out_pred), 64'd0);
        check("reset frame_err", 64'(frame_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready after reset", 64'(in_ready), 64'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Result held under backpressure while pred_in wanders and beats are offered.
        pred_drv  = 3'd2;
        out_ready = 1'b0;
        send_frame(48'h13579BDF2468, 12, 1'b1);
        wait_result(n);
        check("bp latency", 64'(n), 64'd49);
        for (int i = 0; i < 10; i++) begin
            pred_drv = 3'(i % 6);
            in_valid = 1'b1; in_last = 1'b1; in_feat = 4'h7;
            @(posedge clk); #1;
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp out_pred", 64'(out_pred), 64'd2);
            check("bp in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("bp features held", 64'(features), 64'h13579BDF2468);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp in_ready after hs", 64'(in_ready), 64'd1);
        check("bp out_valid after hs", 64'(out_valid), 64'd0);

        // Asynchronous reset in the middle of HOLD.
        pred_drv = 3'd5;
        send_frame(48'h0123456789AB, 12, 1'b1);
        repeat (20) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        check("async rst clf_rst", 64'(clf_rst), 64'd1);
        check("async rst in_ready", 64'(in_ready), 64'd1);
        check("async rst features", 64'(features), 64'd0);
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst frame_err", 64'(frame_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        hits = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid || frame_err) hits++;
        end
        check("no result after rst", 64'(hits), 64'd0);
        run_vec(vecs[4]);

        // Three back-to-back random frames with random valid and ready.
        use_model = 1'b1;
        out_ready = 1'b0;
        fork
            begin
                logic [47:0] fr;
                for (int f = 0; f < 3; f++) begin
                    for (int k = 0; k < 12; k++) fr[k*4 +: 4] = 4'($urandom_range(0, 15));
                    exp_q.push_back(pred_of(fr));
                    for (int k = 0; k < 12; k++) begin
                        bit ok;
                        if ($urandom_range(0, 1) == 1) begin
                            @(posedge clk); #1;
                        end
                        send_beat(fr[k*4 +: 4], k == 11, ok);
                        if (!ok) $display("FAIL random beat: got not-accepted expected accepted");
                    end
                end
            end
            begin
                int got;
                int cyc;
                got = 0;
                cyc = 0;
                while (got < 3 && cyc < 5000) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() > 0) check("random result", 64'(out_pred), 64'(exp_q.pop_front()));
                        else check("random result unexpected", 64'(out_valid), 64'd0);
                        got++;
                    end
                    cyc++;
                end
                check("random result count", 64'(got), 64'd3);
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("random queue drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
